// File: rtl/conv_seq.sv
// conv_seq: sequential 1-D convolution controller over X/Y read ports.
// Produces Z[i] = sum X[j]*Y[i-j], one MAC per cycle, one Z write per i.
module conv_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH:0]     size_x_i,
  input  logic [ADDR_WIDTH:0]     size_y_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDR_WIDTH-1:0]   x_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]   x_rd_data_i,
  output logic [ADDR_WIDTH-1:0]   y_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]   y_rd_data_i,
  output logic                    z_we_o,
  output logic [ADDR_WIDTH:0]     z_wr_addr_o,
  output logic [2*DATA_WIDTH-1:0] z_wr_data_o
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam int DW = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] MAXN = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, SETUP, READ, DRAIN, WRITE, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] nx, ny, i, j, j_hi;
  logic [DW-1:0] acc;
  logic          rd_valid;

  logic [CW-1:0] sat_x, sat_y;
  logic [CW-1:0] j_lo_c, j_hi_c, j_nx, i_nx;
  logic [AW-1:0] y_lo, y_nx;
  logic [CW:0]   n_z;
  logic [DW-1:0] prod, acc_nx;

  assign sat_x = (size_x_i > MAXN) ? MAXN : size_x_i;
  assign sat_y = (size_y_i > MAXN) ? MAXN : size_y_i;

  // Valid j window for the current output index i.
  assign j_lo_c = (i >= ny) ? i - ny + CW'(1) : '0;
  assign j_hi_c = (i < nx) ? i : nx - CW'(1);
  assign j_nx   = j + CW'(1);
  assign i_nx   = i + CW'(1);

  // i-j always fits in AW bits, so modular subtraction is exact.
  assign y_lo = i[AW-1:0] - j_lo_c[AW-1:0];
  assign y_nx = i[AW-1:0] - j_nx[AW-1:0];

  assign n_z = {1'b0, nx} + {1'b0, ny} - (CW+1)'(1);

  assign prod = {{DATA_WIDTH{1'b0}}, x_rd_data_i}
              * {{DATA_WIDTH{1'b0}}, y_rd_data_i};
  assign acc_nx = acc + (rd_valid ? prod : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      nx          <= '0;
      ny          <= '0;
      i           <= '0;
      j           <= '0;
      j_hi        <= '0;
      acc         <= '0;
      rd_valid    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      z_we_o      <= 1'b0;
      x_rd_addr_o <= '0;
      y_rd_addr_o <= '0;
      z_wr_addr_o <= '0;
      z_wr_data_o <= '0;
    end else begin
      // Read data lags the address by one cycle.
      rd_valid <= (state == READ);
      unique case (state)
        IDLE: begin
          if (start_i) begin
            nx     <= sat_x;
            ny     <= sat_y;
            i      <= '0;
            busy_o <= 1'b1;
            if (sat_x == '0 || sat_y == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          acc         <= '0;
          j           <= j_lo_c;
          j_hi        <= j_hi_c;
          x_rd_addr_o <= j_lo_c[AW-1:0];
          y_rd_addr_o <= y_lo;
          state       <= READ;
        end
        READ: begin
          acc <= acc_nx;
          if (j == j_hi) begin
            state <= DRAIN;
          end else begin
            j           <= j_nx;
            x_rd_addr_o <= j_nx[AW-1:0];
            y_rd_addr_o <= y_nx;
          end
        end
        DRAIN: begin
          acc         <= acc_nx;
          z_we_o      <= 1'b1;
          z_wr_addr_o <= i;
          z_wr_data_o <= acc_nx;
          state       <= WRITE;
        end
        WRITE: begin
          z_we_o <= 1'b0;
          i      <= i_nx;
          if ({1'b0, i_nx} < n_z) begin
            state <= SETUP;
          end else begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq: random and directed runs of conv_seq checked
// against a loop-based convolution model with cycle accounting.
module tb_conv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  size_x, size_y;
  logic        busy, done;
  logic [4:0]  x_rd_addr, y_rd_addr;
  logic [7:0]  x_rd_data, y_rd_data;
  logic        z_we;
  logic [5:0]  z_wr_addr;
  logic [15:0] z_wr_data;

  logic [7:0]  xm [32];
  logic [7:0]  ym [32];
  int          ez [64];
  int          n_chk = 0;
  int          n_pass = 0;

  conv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .size_x_i    (size_x),
    .size_y_i    (size_y),
    .busy_o      (busy),
    .done_o      (done),
    .x_rd_addr_o (x_rd_addr),
    .x_rd_data_i (x_rd_data),
    .y_rd_addr_o (y_rd_addr),
    .y_rd_data_i (y_rd_data),
    .z_we_o      (z_we),
    .z_wr_addr_o (z_wr_addr),
    .z_wr_data_o (z_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    x_rd_data <= xm[x_rd_addr];
    y_rd_data <= ym[y_rd_addr];
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Direct convolution over the valid j range, plus cycle budget.
  task automatic model(input int nx, input int ny,
                       output int nz, output int cyc);
    nz  = (nx == 0 || ny == 0) ? 0 : nx + ny - 1;
    cyc = 1;
    for (int k = 0; k < nz; k++) begin
      int s = 0;
      int n = 0;
      for (int m = 0; m < nx; m++)
        if (m <= k && k - m < ny) begin
          s += int'(xm[m]) * int'(ym[k-m]);
          n++;
        end
      ez[k] = s & 32'hFFFF;
      cyc += n + 3;
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 32; k++) begin
      xm[k] = 8'($urandom);
      ym[k] = 8'($urandom);
    end
  endtask

  // Enters in an IDLE cycle, leaves in the IDLE cycle after DONE.
  task automatic run(input int sx, input int sy, input bit hold);
    int nx, ny, enz, ecyc, cyc, nw;
    bit busy_ok, seen;
    nx = (sx > 32) ? 32 : sx;
    ny = (sy > 32) ? 32 : sy;
    model(nx, ny, enz, ecyc);
    size_x = 6'(sx);
    size_y = 6'(sy);
    start  = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    size_x  = 6'($urandom);
    size_y  = 6'($urandom);
    cyc     = 1;
    nw      = 0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (!seen && cyc <= ecyc + 50) begin
      if (z_we) begin
        chk("z_addr", 64'(z_wr_addr), 64'(nw));
        chk("z_data", 64'(z_wr_data), 64'(ez[nw % 64]));
        nw++;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_cyc", 64'(cyc), 64'(ecyc));
    chk("n_writes", 64'(nw), 64'(enz));
    chk("busy_run", 64'(busy_ok), 64'd1);
    @(posedge clk); #1;
    chk("busy_idle", 64'(busy), 64'd0);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int cnt;
    rst    = 1'b1;
    start  = 1'b0;
    size_x = '0;
    size_y = '0;
    for (int k = 0; k < 32; k++) begin
      xm[k] = '0;
      ym[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", 64'(z_we), 64'd0);
    chk("rst_xa", 64'(x_rd_addr), 64'd0);
    chk("rst_ya", 64'(y_rd_addr), 64'd0);
    chk("rst_za", 64'(z_wr_addr), 64'd0);
    chk("rst_zd", 64'(z_wr_data), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    xm[0] = 8'd1; xm[1] = 8'd2; xm[2] = 8'd3;
    ym[0] = 8'd1; ym[1] = 8'd1;
    run(3, 2, 1'b0);

    xm[0] = 8'd255; ym[0] = 8'd255;
    run(1, 1, 1'b0);

    run(0, 5, 1'b0);
    run(4, 0, 1'b0);

    fill_rand();
    run(3, 2, 1'b1);
    run(3, 2, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("hold_stop", 64'(busy), 64'd0);

    for (int k = 0; k < 32; k++) begin
      xm[k] = 8'd255;
      ym[k] = 8'd255;
    end
    run(32, 32, 1'b0);
    run(63, 1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      fill_rand();
      run(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 1'b0);
    end

    xm[0] = 8'd1; xm[1] = 8'd2; xm[2] = 8'd3;
    ym[0] = 8'd1; ym[1] = 8'd1;
    size_x = 6'd3;
    size_y = 6'd2;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_we", 64'(z_we), 64'd0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (z_we || done || busy) cnt++;
      @(posedge clk); #1;
    end
    chk("abort_quiet", 64'(cnt), 64'd0);

    fill_rand();
    run(5, 7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
